soma_spk_pack: RTL
==================

# soma_spk_pack

Spike packetiser directly downstream of the soma stage. Captures each neuron fire decision (`soma_spk_out_fire`, qualified by the soma's registered evaluation strobe) into a small FIFO. For every buffered spike, walks the node's destination table and emits one spike flit per valid destination toward the router over a valid/ready handshake. Drops spikes when the buffer is full and reports drops in saturating status counters.

## Interface
- FW, 59, flit width
- FTW, 3, flit type width
- NNW, 12, neuron number width
- DST_WIDTH, 21, destination entry width {x,y,r2,r1,flg}; bit 0 = flg (entry valid)
- DST_DEPTH, 4, destination entries per node (power of 2)
- FIFO_DEPTH, 16, spike buffer depth (power of 2)

Ports:
- clk_soma  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- soma_fire_vld  in  1  fire decision valid this cycle (soma evaluation strobe delayed by one cycle)
- soma_spk_out_fire  in  1  fire decision
- soma_fire_addr  in  NNW  neuron address of the decision (soma evaluation address delayed by one cycle)
- config_dst_we  in  1  destination table write strobe
- config_dst_waddr  in  log2(DST_DEPTH)  table write index
- config_dst_wdata  in  DST_WIDTH  table write data
- config_cnt_clear  in  1  synchronous clear of status counters
- flit_out_vld  out  1  flit valid
- flit_out_rdy  in  1  downstream ready
- flit_out_data  out  FW  flit
- spk_busy  out  1  FIFO non-empty or FSM not IDLE
- spk_drop_cnt  out  16  dropped spikes, saturating at 16'hFFFF
- spk_sent_cnt  out  16  accepted flits, saturating

## Operation
- Push: soma_fire_vld && soma_spk_out_fire writes soma_fire_addr into the FIFO.
  - If the FIFO holds FIFO_DEPTH entries at that edge, the spike is dropped and spk_drop_cnt increments.
  - The full check uses pre-pop occupancy: a push while full is dropped even if a pop occurs in the same cycle.
- Destination table: DST_DEPTH x DST_WIDTH registers, reset to 0 (all invalid), read combinationally.
  - A write takes effect from the next cycle, including mid-scan.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into cur_addr, set idx=0, go to SCAN.
  - SCAN, entry[idx].flg==1: drive flit_out_vld. On vld&&rdy, increment spk_sent_cnt and advance.
  - SCAN, entry[idx].flg==0: advance after one cycle with no flit.
  - Advance when idx<DST_DEPTH-1: idx++.
  - Advance when idx==DST_DEPTH-1: if FIFO non-empty, pop into cur_addr, set idx=0, stay in SCAN; else go to IDLE.
- Flit format, MSB to LSB:
  - type[FTW] = 3'b010 (SPIKE)
  - dst = entry[idx][DST_WIDTH-1:1] (20 bits)
  - neuron = cur_addr (NNW)
  - zero pad (FW-FTW-DST_WIDTH+1-NNW = 24 bits)
- Handshake: once flit_out_vld rises, flit_out_vld and flit_out_data stay stable until accepted. A table write to the entry being presented does not alter the held flit, because the flit is registered.
- Counters: config_cnt_clear zeroes both counters; clear wins over a same-cycle increment.

## Timing
- Reset values:
  - flit_out_vld=0, flit_out_data=0, spk_busy=0, both counters 0.
  - FIFO empty, FSM IDLE, table cleared.
- flit_out_data and flit_out_vld are registered outputs.
- Latency: a fire pushed at edge N is popped at edge N+1. Its first flit (entry 0 valid) is presented after edge N+2.
- Throughput: one flit per cycle with rdy held high. Invalid entries cost one bubble cycle each.
- Full-pipeline back-to-back spikes: the pop for the next spike occurs at the edge accepting the last destination, so there are no extra idle cycles.
- Reset mid-scan: the held flit is abandoned (vld drops immediately) and buffered spikes are lost. Downstream must tolerate this.
- spk_busy is combinational from FSM state and FIFO empty.

## Structure
- Shared package:
  - flit type constants (SPIKE=3'b010)
  - flit field offsets and widths
  - destination-entry field positions (flg bit 0)
  - FSM state enum {IDLE, SCAN}
- Sub-module `spk_fifo`: synchronous FIFO, width NNW, depth FIFO_DEPTH, with push/pop/full/empty and pointer wrap.
- Packetiser FSM, table and counters live in the top level.

## Test plan
- Table entries 0 and 2 valid with dst 20'h12345/20'h00ABC; fire addr 12'h05A; rdy=1 -> exactly 2 flits, {3'b010,20'h12345,12'h05A,24'h0} then the 20'h00ABC flit; first flit vld 2 cycles after fire; spk_sent_cnt=2.
- All 4 entries valid, rdy low for 5 cycles at the second flit -> flit_out_data stable and vld held for 5 cycles; no loss or duplication.
- 20 fires in consecutive cycles with rdy=0 -> 16 buffered, spk_drop_cnt=4; release rdy -> 64 flits in FIFO order, addresses ascending.
- FIFO full, push and pop in the same cycle -> push dropped, drop count +1, occupancy becomes 15; wrap test with 40 push/pop cycles -> order preserved.
- Table all invalid, fire -> no flits; spk_busy high 1+DST_DEPTH cycles, then IDLE.
- Assert rst_n low while a flit is pending -> vld=0 immediately; after release the table is cleared, so a fire yields no flits and counters read 0.

Source files
------------

// File: rtl/soma_spk_pack_pkg.sv
// soma_spk_pack_pkg
//   Shared constants and types for the spike packetiser: block widths,
//   spike-flit field layout, destination-entry field positions, the
//   packetiser FSM state type and a flit builder helper.
//   No ports.
package soma_spk_pack_pkg;

  localparam int FW         = 59;  // flit width
  localparam int FTW        = 3;   // flit type width
  localparam int NNW        = 12;  // neuron number width
  localparam int DST_WIDTH  = 21;  // destination entry {x,y,r2,r1,flg}
  localparam int DST_DEPTH  = 4;   // destination entries per node
  localparam int FIFO_DEPTH = 16;  // spike buffer depth

  localparam int DST_IDX_W   = $clog2(DST_DEPTH);
  localparam int DST_FIELD_W = DST_WIDTH - 1;               // entry without flg
  localparam int PAD_W       = FW - FTW - DST_FIELD_W - NNW; // 24 zero bits

  // Flit field offsets, MSB to LSB: type | dst | neuron | pad
  localparam int FLIT_TYPE_LSB = FW - FTW;
  localparam int FLIT_DST_LSB  = FLIT_TYPE_LSB - DST_FIELD_W;
  localparam int FLIT_NRN_LSB  = FLIT_DST_LSB - NNW;

  localparam logic [FTW-1:0] FLIT_SPIKE = 3'b010;

  // Destination entry: bit 0 marks the entry as valid, the rest is routed as-is
  localparam int DST_FLG_BIT = 0;
  localparam int DST_FIELD_LSB = 1;

  typedef enum logic {
    IDLE,
    SCAN
  } pack_state_e;

  function automatic logic [FW-1:0] make_spike_flit(
    input logic [DST_FIELD_W-1:0] dst,
    input logic [NNW-1:0]         addr
  );
    return {FLIT_SPIKE, dst, addr, {PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/spk_fifo.sv
// spk_fifo
//   Synchronous FIFO buffering neuron addresses of fired spikes.
//   A push while full and a pop while empty are ignored, so the
//   parent only has to qualify its requests for accounting.
// Ports:
//   clk_soma  in   clock
//   rst_n     in   asynchronous active-low reset (empties the FIFO)
//   push_i    in   write data_i at the tail
//   pop_i     in   discard the head
//   data_i    in   WIDTH  write data
//   data_o    out  WIDTH  current head (valid when !empty_o)
//   full_o    out  DEPTH entries held
//   empty_o   out  no entries held
module spk_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic             clk_soma,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read behind the write pointer
  always_ff @(posedge clk_soma) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/soma_spk_pack.sv
// soma_spk_pack
//   Spike packetiser behind the soma stage. Buffers fired neuron
//   addresses in a FIFO and, per buffered spike, walks the destination
//   table emitting one registered spike flit per valid entry over a
//   valid/ready handshake. Spikes arriving while the buffer is full are
//   dropped and counted.
// Ports:
//   clk_soma           in   clock
//   rst_n              in   asynchronous active-low reset
//   soma_fire_vld      in   fire decision valid this cycle
//   soma_spk_out_fire  in   fire decision
//   soma_fire_addr     in   NNW neuron address of the decision
//   config_dst_we      in   destination table write strobe
//   config_dst_waddr   in   table write index
//   config_dst_wdata   in   DST_WIDTH table write data
//   config_cnt_clear   in   synchronous clear of both status counters
//   flit_out_vld       out  flit valid (registered)
//   flit_out_rdy       in   downstream ready
//   flit_out_data      out  FW flit (registered)
//   spk_busy           out  FIFO non-empty or FSM not idle
//   spk_drop_cnt       out  dropped spikes, saturating
//   spk_sent_cnt       out  accepted flits, saturating
module soma_spk_pack
  import soma_spk_pack_pkg::*;
(
  input  logic                 clk_soma,
  input  logic                 rst_n,
  input  logic                 soma_fire_vld,
  input  logic                 soma_spk_out_fire,
  input  logic [NNW-1:0]       soma_fire_addr,
  input  logic                 config_dst_we,
  input  logic [DST_IDX_W-1:0] config_dst_waddr,
  input  logic [DST_WIDTH-1:0] config_dst_wdata,
  input  logic                 config_cnt_clear,
  output logic                 flit_out_vld,
  input  logic                 flit_out_rdy,
  output logic [FW-1:0]        flit_out_data,
  output logic                 spk_busy,
  output logic [15:0]          spk_drop_cnt,
  output logic [15:0]          spk_sent_cnt
);

  logic                 fire_req;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [NNW-1:0]       fifo_head;

  logic [DST_WIDTH-1:0] dst_tbl_q [DST_DEPTH];
  pack_state_e          state_q;
  logic [DST_IDX_W-1:0] idx_q;
  logic [NNW-1:0]       cur_addr_q;
  logic                 flit_vld_q;
  logic [FW-1:0]        flit_data_q;
  logic [15:0]          drop_cnt_q, sent_cnt_q;

  logic [DST_WIDTH-1:0] cur_entry, adv_entry;
  logic [DST_IDX_W-1:0] adv_idx;
  logic [NNW-1:0]       adv_addr;
  logic                 slot_done, last_idx, flit_accept;

  assign fire_req = soma_fire_vld && soma_spk_out_fire;

  // The FIFO ignores a push while full, which makes the drop decision use
  // pre-pop occupancy even when the FSM pops on the same edge.
  spk_fifo #(
    .WIDTH (NNW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_soma (clk_soma),
    .rst_n    (rst_n),
    .push_i   (fire_req),
    .pop_i    (fifo_pop),
    .data_i   (soma_fire_addr),
    .data_o   (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // A slot (one table entry) is finished when its flit is accepted or, for
  // an invalid entry, after a single bubble cycle. On finishing, the next
  // entry is looked up right away so valid entries stream at one per cycle;
  // after the last entry the next spike is popped on the same edge.
  always_comb begin
    cur_entry   = dst_tbl_q[idx_q];
    flit_accept = flit_vld_q && flit_out_rdy;
    last_idx    = (idx_q == DST_IDX_W'(DST_DEPTH - 1));
    slot_done   = (state_q == SCAN) &&
                  (flit_vld_q ? flit_out_rdy : !cur_entry[DST_FLG_BIT]);
    fifo_pop    = !fifo_empty && ((state_q == IDLE) || (slot_done && last_idx));
    adv_idx     = last_idx ? '0 : idx_q + 1'b1;
    adv_addr    = last_idx ? fifo_head : cur_addr_q;
    adv_entry   = dst_tbl_q[adv_idx];
  end

  // Packetiser FSM with registered flit outputs. Leaving IDLE takes one
  // cycle before the first flit is registered; later slots are preloaded.
  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cur_addr_q  <= '0;
      flit_vld_q  <= 1'b0;
      flit_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            cur_addr_q <= fifo_head;
            idx_q      <= '0;
            state_q    <= SCAN;
          end
        end
        SCAN: begin
          if (slot_done) begin
            if (last_idx && fifo_empty) begin
              flit_vld_q <= 1'b0;
              state_q    <= IDLE;
            end else begin
              idx_q      <= adv_idx;
              cur_addr_q <= adv_addr;
              flit_vld_q <= adv_entry[DST_FLG_BIT];
              if (adv_entry[DST_FLG_BIT])
                flit_data_q <= make_spike_flit(adv_entry[DST_WIDTH-1:DST_FIELD_LSB], adv_addr);
            end
          end else if (!flit_vld_q) begin
            // Current entry is valid but its flit has not been registered yet
            flit_vld_q  <= 1'b1;
            flit_data_q <= make_spike_flit(cur_entry[DST_WIDTH-1:DST_FIELD_LSB], cur_addr_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DST_DEPTH; i++) dst_tbl_q[i] <= '0;
    end else if (config_dst_we) begin
      dst_tbl_q[config_dst_waddr] <= config_dst_wdata;
    end
  end

  // Saturating status counters; a clear overrides a same-cycle increment
  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      sent_cnt_q <= '0;
    end else if (config_cnt_clear) begin
      drop_cnt_q <= '0;
      sent_cnt_q <= '0;
    end else begin
      if (fire_req && fifo_full && (drop_cnt_q != 16'hFFFF))
        drop_cnt_q <= drop_cnt_q + 16'd1;
      if (flit_accept && (sent_cnt_q != 16'hFFFF))
        sent_cnt_q <= sent_cnt_q + 16'd1;
    end
  end

  assign flit_out_vld  = flit_vld_q;
  assign flit_out_data = flit_data_q;
  assign spk_busy      = (state_q != IDLE) || !fifo_empty;
  assign spk_drop_cnt  = drop_cnt_q;
  assign spk_sent_cnt  = sent_cnt_q;

endmodule
